so_ctx_scheduler: RTL

Operating-system control block for the RVSP core.
- Holds the core in BIOS mode after reset, then hands control to the kernel.
- Runs user processes in round-robin time slices.
- Drives the active process ID to memory/register-bank selection and requests a context save/restore handshake on every switch.
- Parametrised in process count and quantum length; generalises the single-bit BIOS/PID controller.

---
 rtl/so_pkg.sv | 24 ++
 rtl/so_rr_pick.sv | 34 +++
 rtl/so_ctx_scheduler.sv | 130 +++++++++++++
 3 files changed

// File: rtl/so_pkg.sv
`default_nettype none
// ============================================================================
// Module  : so_pkg
// Brief   : Shared types and encodings for the RVSP OS context scheduler.
// Rev     : 1.0
// ============================================================================
package so_pkg;

    typedef enum logic [1:0] {
        ST_BIOS   = 2'd0,
        ST_KERNEL = 2'd1,
        ST_RUN    = 2'd2,
        ST_SWITCH = 2'd3
    } state_t;

    localparam logic [1:0] CAUSE_NONE    = 2'd0;
    localparam logic [1:0] CAUSE_HALT    = 2'd1;
    localparam logic [1:0] CAUSE_QUANTUM = 2'd2;
    localparam logic [1:0] CAUSE_SET_CTX = 2'd3;

    localparam int KERNEL_PID = 0;

endpackage
`default_nettype wire

// File: rtl/so_rr_pick.sv
`default_nettype none
// ============================================================================
// Module  : so_rr_pick
// Brief   : Combinational round-robin pick of the next runnable user PID.
// Rev     : 1.0
// ============================================================================
module so_rr_pick #(
    parameter int PID_W = 2
) (
    input  logic [2**PID_W-1:0] ready_mask,
    input  logic [PID_W-1:0]    cur_pid,
    output logic [PID_W-1:0]    next_pid,
    output logic                found
);
    localparam int NPROC = 2**PID_W;

    logic [PID_W-1:0] w_cand;

    // Offsets 1..NPROC wrap modulo NPROC, so the current PID is visited last.
    always_comb begin
        next_pid = '0;
        found    = 1'b0;
        w_cand   = '0;
        for (int k = 1; k <= NPROC; k++) begin
            w_cand = cur_pid + PID_W'(k);
            if (!found && (w_cand != '0) && ready_mask[w_cand]) begin
                found    = 1'b1;
                next_pid = w_cand;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/so_ctx_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : so_ctx_scheduler
// Brief   : BIOS/kernel hand-off and round-robin process scheduler with
//           context save/restore handshake. SO_PREEMPT_EN enables the
//           quantum timer; otherwise scheduling is cooperative.
// Rev     : 1.0
// ============================================================================
module so_ctx_scheduler
    import so_pkg::*;
#(
    parameter int PID_W   = 2,
    parameter int QUANT_W = 8,
    parameter int QUANTUM = 100
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                halt,
    input  logic                set_ctx,
    input  logic [PID_W-1:0]    new_pid,
    input  logic [2**PID_W-1:0] ready_mask,
    input  logic                ctx_ack,
    output logic                sel_bios,
    output logic [PID_W-1:0]    pid,
    output logic                ctx_req,
    output logic [1:0]          switch_cause,
    output logic [QUANT_W-1:0]  quantum_left
);
    localparam logic [PID_W-1:0] c_kernel_pid = PID_W'(KERNEL_PID);

    if ((QUANTUM < 1) || (QUANTUM > 2**QUANT_W - 1)) begin : g_bad_quantum
        $error("so_ctx_scheduler: QUANTUM out of range");
    end

    state_t           r_state;
    logic [PID_W-1:0] r_target;
    logic [PID_W-1:0] w_rr_pid;
    logic             w_rr_found;

    so_rr_pick #(
        .PID_W (PID_W)
    ) u_rr_pick (
        .ready_mask (ready_mask),
        .cur_pid    (pid),
        .next_pid   (w_rr_pid),
        .found      (w_rr_found)
    );

`ifdef SO_PREEMPT_EN
    logic [QUANT_W-1:0] r_quantum;
    assign quantum_left = r_quantum;
`else
    assign quantum_left = '0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_BIOS;
            r_target     <= c_kernel_pid;
            sel_bios     <= 1'b1;
            pid          <= c_kernel_pid;
            ctx_req      <= 1'b0;
            switch_cause <= CAUSE_NONE;
`ifdef SO_PREEMPT_EN
            r_quantum    <= '0;
`endif
        end else begin
            case (r_state)
                ST_BIOS: begin
                    if (halt) begin
                        r_state  <= ST_KERNEL;
                        sel_bios <= 1'b0;
                    end
                end
                ST_KERNEL: begin
                    if (set_ctx && (new_pid != c_kernel_pid)) begin
                        r_state      <= ST_SWITCH;
                        r_target     <= new_pid;
                        switch_cause <= CAUSE_SET_CTX;
                        ctx_req      <= 1'b1;
                    end
                end
                ST_RUN: begin
`ifdef SO_PREEMPT_EN
                    r_quantum <= r_quantum - 1'b1;
`endif
                    if (set_ctx) begin
                        r_state      <= ST_SWITCH;
                        r_target     <= new_pid;
                        switch_cause <= CAUSE_SET_CTX;
                        ctx_req      <= 1'b1;
                    end else if (halt) begin
                        r_state      <= ST_SWITCH;
                        r_target     <= w_rr_found ? w_rr_pid : c_kernel_pid;
                        switch_cause <= CAUSE_HALT;
                        ctx_req      <= 1'b1;
                    end
`ifdef SO_PREEMPT_EN
                    else if (r_quantum == QUANT_W'(1)) begin
                        r_state      <= ST_SWITCH;
                        r_target     <= w_rr_found ? w_rr_pid : c_kernel_pid;
                        switch_cause <= CAUSE_QUANTUM;
                        ctx_req      <= 1'b1;
                    end
`endif
                end
                ST_SWITCH: begin
                    if (ctx_ack) begin
                        ctx_req <= 1'b0;
                        pid     <= r_target;
                        if (r_target != c_kernel_pid) begin
                            r_state   <= ST_RUN;
`ifdef SO_PREEMPT_EN
                            r_quantum <= QUANT_W'(QUANTUM);
`endif
                        end else begin
                            r_state   <= ST_KERNEL;
`ifdef SO_PREEMPT_EN
                            r_quantum <= '0;
`endif
                        end
                    end
                end
                default: r_state <= ST_BIOS;
            endcase
        end
    end

endmodule
`default_nettype wire
